// File: rtl/rr_arbiter_n.sv
// Round-robin / fixed-priority arbiter with registered one-hot grant and a
// bounded lock that lets the current owner keep its grant for up to MAX_HOLD cycles.
module rr_arbiter_n #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOLD   = 8,
  parameter int FIXED_PRIO = 0,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] request,
  input  logic               lock,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id
);

  logic [IDW-1:0]     ptr, ptr_nxt;
  logic [7:0]         hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               valid_nxt;
  logic [IDW-1:0]     id_nxt;

  logic               hold;
  logic               found;
  logic [IDW-1:0]     winner;

  // Search one extra bit wide so ptr+k never overflows before the modulo fold;
  // this keeps non-power-of-two NUM_REQ from ever selecting a missing index.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && request[i]) begin
          found  = 1'b1;
          winner = IDW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        sum = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
        idx = sum[IDW-1:0];
        if (!found && request[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  assign hold = grant_valid && lock && (|(request & grant)) &&
                (hold_cnt < 8'(MAX_HOLD));

  always_comb begin
    grant_nxt    = grant;
    valid_nxt    = grant_valid;
    id_nxt       = grant_id;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    if (hold) begin
      hold_cnt_nxt = hold_cnt + 8'd1;
    end else if (found) begin
      grant_nxt    = NUM_REQ'(1) << winner;
      valid_nxt    = 1'b1;
      id_nxt       = winner;
      ptr_nxt      = winner;
      hold_cnt_nxt = 8'd1;
    end else begin
      // Idle: outputs clear but the pointer keeps its place in the rotation.
      grant_nxt    = '0;
      valid_nxt    = 1'b0;
      id_nxt       = '0;
      hold_cnt_nxt = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= 8'd0;
      ptr         <= IDW'(NUM_REQ - 1);
    end else begin
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      grant_id    <= id_nxt;
      hold_cnt    <= hold_cnt_nxt;
      ptr         <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: a behavioural model pushes expected grants
// as stimulus is driven; they are popped and compared one cycle later.
module tb_rr_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Round-robin instance under the main scoreboard.
  logic [3:0] req;
  logic       lock;
  logic [3:0] g;
  logic       gv;
  logic [1:0] gid;

  // Fixed-priority, three requesters.
  logic [2:0] req3;
  logic       lock3;
  logic [2:0] g3;
  logic       gv3;
  logic [1:0] gid3;

  // Five requesters, MAX_HOLD=1 (lock inert, non-power-of-two wrap).
  logic [4:0] req5;
  logic       lock5;
  logic [4:0] g5;
  logic       gv5;
  logic [2:0] gid5;

  rr_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(3), .FIXED_PRIO(0)) u0 (
    .clk(clk), .rst_n(rst_n), .request(req), .lock(lock),
    .grant(g), .grant_valid(gv), .grant_id(gid)
  );

  rr_arbiter_n #(.NUM_REQ(3), .MAX_HOLD(3), .FIXED_PRIO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .request(req3), .lock(lock3),
    .grant(g3), .grant_valid(gv3), .grant_id(gid3)
  );

  rr_arbiter_n #(.NUM_REQ(5), .MAX_HOLD(1), .FIXED_PRIO(0)) u2 (
    .clk(clk), .rst_n(rst_n), .request(req5), .lock(lock5),
    .grant(g5), .grant_valid(gv5), .grant_id(gid5)
  );

  typedef struct {
    logic [3:0] g;
    logic       gv;
    logic [1:0] id;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int m_own = -1;
  int m_ptr = 3;
  int m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = 3;
    m_cnt = 0;
  endtask

  // Drive one cycle on u0, predict, then compare after the edge.
  task automatic drive(input logic [3:0] r, input logic l);
    exp_t e;
    exp_t o;
    bit   hold;
    int   win;
    int   c;
    @(negedge clk);
    req  = r;
    lock = l;
    hold = 1'b0;
    if (m_own >= 0 && l && m_cnt < 3) hold = r[m_own[1:0]];
    if (hold) begin
      m_cnt++;
    end else begin
      win = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (win < 0 && r[c[1:0]]) win = c;
      end
      if (win >= 0) begin
        m_own = win;
        m_ptr = win;
        m_cnt = 1;
      end else begin
        m_own = -1;
        m_cnt = 0;
      end
    end
    e.g   = (m_own >= 0) ? 4'(1 << m_own) : 4'd0;
    e.gv  = (m_own >= 0);
    e.id  = (m_own >= 0) ? 2'(m_own) : 2'd0;
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check("grant",    32'(g),           32'(o.g));
    check("valid",    32'(gv),          32'(o.gv));
    check("id",       32'(gid),         32'(o.id));
    check("hold_cnt", 32'(u0.hold_cnt), 32'(o.cnt));
    check("onehot0",  32'($onehot0(g)), 32'd1);
  endtask

  task automatic tick3(input logic [2:0] r, input logic l);
    @(negedge clk);
    req3  = r;
    lock3 = l;
    @(posedge clk);
    #1;
  endtask

  task automatic tick5(input logic [4:0] r, input logic l);
    @(negedge clk);
    req5  = r;
    lock5 = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq29 [8];
    int         ids30 [7];
    int         cnt32 [7];
    seq29 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ids30 = '{1, 1, 1, 3, 3, 3, 1};
    cnt32 = '{1, 2, 3, 1, 2, 3, 1};

    rst_n = 1'b0;
    req = '0;  lock = 1'b0;
    req3 = '0; lock3 = 1'b0;
    req5 = '0; lock5 = 1'b0;
    #12;
    check("rst_grant", 32'(g),           32'd0);
    check("rst_valid", 32'(gv),          32'd0);
    check("rst_id",    32'(gid),         32'd0);
    check("rst_cnt",   32'(u0.hold_cnt), 32'd0);
    check("rst_ptr",   32'(u0.ptr),      32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Full request rotation.
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b0);
      check("rr_seq", 32'(g), 32'(seq29[i]));
    end

    // Lock on two requesters alternates after MAX_HOLD cycles.
    drive(4'b0000, 1'b0);
    check("idle_valid", 32'(gv), 32'd0);
    for (int i = 0; i < 7; i++) begin
      drive(4'b1010, 1'b1);
      check("lock_id", 32'(gid), 32'(ids30[i]));
    end

    // Owner drops request while locked.
    drive(4'b0100, 1'b1);
    check("own2", 32'(g), 32'b0100);
    drive(4'b0001, 1'b1);
    check("drop_grant", 32'(g),   32'b0001);
    check("drop_id",    32'(gid), 32'd0);

    // Sole requester re-granted after expiry.
    for (int i = 0; i < 7; i++) begin
      drive(4'b0100, 1'b1);
      check("solo_grant", 32'(g),           32'b0100);
      check("solo_cnt",   32'(u0.hold_cnt), 32'(cnt32[i]));
    end
    drive(4'b0000, 1'b1);
    check("none_valid", 32'(gv),  32'd0);
    check("none_id",    32'(gid), 32'd0);

    // Asynchronous reset mid-hold on requester 3.
    drive(4'b1000, 1'b1);
    drive(4'b1000, 1'b1);
    check("pre_rst_cnt", 32'(u0.hold_cnt), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(g),           32'd0);
    check("async_valid", 32'(gv),          32'd0);
    check("async_id",    32'(gid),         32'd0);
    check("async_cnt",   32'(u0.hold_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(4'b1001, 1'b1);
    check("post_rst", 32'(g), 32'b0001);

    // Random traffic, lock mostly asserted to exercise holds.
    for (int i = 0; i < 80; i++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    // Fixed priority: lowest set index wins.
    for (int i = 0; i < 4; i++) begin
      tick3(3'b111, 1'b0);
      check("fp_111", 32'(g3), 32'b001);
    end
    for (int i = 0; i < 3; i++) begin
      tick3(3'b110, 1'b0);
      check("fp_110",    32'(g3),   32'b010);
      check("fp_110_id", 32'(gid3), 32'd1);
    end
    tick3(3'b000, 1'b0);
    check("fp_idle", 32'(gv3), 32'd0);

    // MAX_HOLD=1: lock is inert, rotation wraps 4 -> 0.
    for (int i = 0; i < 6; i++) begin
      tick5(5'b11111, 1'b1);
      check("mh1_grant", 32'(g5),   32'(1 << (i % 5)));
      check("mh1_id",    32'(gid5), 32'(i % 5));
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive cycles one owner may hold a locked grant; legal range 1..255.
REQ-003 Parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Parameter IDW = max(1, clog2(NUM_REQ)), derived; not to be overridden.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 request  input  NUM_REQ  per-requester request, level-sensitive.
REQ-008 lock  input  1  current owner asks to keep its grant next cycle.
REQ-009 grant  output  NUM_REQ  registered grant, one-hot or all-zero.
REQ-010 grant_valid  output  1  registered; 1 when grant is non-zero.
REQ-011 grant_id  output  IDW  registered binary index of granted requester; 0 when grant_valid=0.

Function
REQ-012 grant, grant_valid and grant_id SHALL be registered outputs with exactly one cycle latency from the sampled request/lock.
REQ-013 grant SHALL never have more than one bit set; grant_valid SHALL equal OR of grant; grant_id SHALL equal the encoded grant.
REQ-014 Internal state SHALL be: last-owner pointer (IDW bits), hold counter (8 bits), registered grant.
REQ-015 Hold condition: grant_valid=1, lock=1, request[owner]=1 and hold_cnt < MAX_HOLD; when true, grant SHALL stay unchanged and hold_cnt SHALL increment by 1.
REQ-016 When hold condition is false, the block SHALL re-arbitrate over the current request vector.
REQ-017 Round-robin re-arbitration: search starts at pointer+1 and proceeds upward, wrapping from NUM_REQ-1 to 0; first set request wins.
REQ-018 Pointer+1 SHALL wrap modulo NUM_REQ, including non-power-of-two NUM_REQ (indices >= NUM_REQ never granted).
REQ-019 On a new grant (any re-arbitration yielding a winner), pointer SHALL load the winner index and hold_cnt SHALL load 1.
REQ-020 If a lock expires (hold_cnt = MAX_HOLD) and only the owner requests, the owner SHALL be re-granted and hold_cnt SHALL restart at 1.
REQ-021 If no request is set at re-arbitration, grant SHALL go to 0, grant_valid to 0, grant_id to 0, hold_cnt to 0; pointer SHALL retain its value.
REQ-022 lock SHALL be ignored when grant_valid=0 or request[owner]=0; owner dropping request SHALL release the grant the same re-arbitration cycle.
REQ-023 FIXED_PRIO=1: re-arbitration SHALL pick the lowest set index regardless of pointer; lock/MAX_HOLD rules still apply; pointer still updates.
REQ-024 With MAX_HOLD=1, lock SHALL have no effect (every cycle re-arbitrates).
REQ-025 Round-robin fairness: with all requests continuously set and lock=0, each requester SHALL be granted once per NUM_REQ cycles.

Reset
REQ-026 rst_n=0 SHALL immediately (without clock) clear grant, grant_valid, grant_id and hold_cnt to 0 and set pointer to NUM_REQ-1.
REQ-027 Reset asserted mid-hold SHALL abort the hold; after release, arbitration restarts with index 0 highest priority.
REQ-028 First grant after rst_n rises SHALL appear on the first rising clk edge at which rst_n=1 and a request is set.

Verification (NUM_REQ=4, MAX_HOLD=3, FIXED_PRIO=0 unless stated)
REQ-029 After reset, request=4'b1111, lock=0 for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-030 request=4'b1010, lock=1 held -> grant 0010 for 3 cycles, then 1000 for 3 cycles, then 0010; grant_id 1,1,1,3,3,3,1.
REQ-031 Owner 2 granted with lock=1, request[2] drops to 0 while request=4'b0001 -> next cycle grant=0001, grant_id=0.
REQ-032 request=4'b0100 only, lock=1 for 7 cycles -> grant=0100 every cycle, hold_cnt sequence 1,2,3,1,2,3,1; request=0 -> grant_valid=0, grant_id=0.
REQ-033 rst_n pulsed low between clock edges during a hold on requester 3 -> outputs 0 immediately; after release with request=4'b1001 -> first grant=0001.
REQ-034 FIXED_PRIO=1, NUM_REQ=3, request=3'b111, lock=0 -> grant=001 every cycle; request=3'b110 -> grant=010; index 3 never granted.
